// File: rtl/skin_pkg.sv
// skin_pkg: shared defaults and divider state encoding for the skin centroid block.
package skin_pkg;

    localparam int         DEF_X_W      = 11;
    localparam int         DEF_Y_W      = 11;
    localparam int         DEF_CNT_W    = 22;
    localparam int         DEF_SUM_W    = 33;
    localparam logic [7:0] DEF_MASK_THR = 8'd128;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

endpackage

// File: rtl/centroid_div.sv
// centroid_div: restoring divider, one quotient bit per cycle, floor quotient.
// The dividend is shifted out MSB-first while quotient bits shift in at the LSB,
// so one register holds both. Remainder stays below the divisor, so CNT_W bits suffice.
module centroid_div
    import skin_pkg::*;
#(
    parameter int SUM_W = DEF_SUM_W,
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int BW = $clog2(SUM_W);

    div_state_e       r_state, w_next;
    logic [BW-1:0]    r_bit;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_dvs;
    logic [SUM_W-1:0] r_q;
    logic [CNT_W:0]   w_sh;
    logic [CNT_W:0]   w_diff;
    logic             w_ge;

    assign w_sh   = {r_rem, r_q[SUM_W-1]};
    assign w_diff = w_sh - {1'b0, r_dvs};
    assign w_ge   = (w_sh >= {1'b0, r_dvs});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= DIV_IDLE;
        else        r_state <= w_next;
    end

    // Next state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                busy = 1'b0;
                if (start) w_next = DIV_RUN;
            end
            DIV_RUN:  if (r_bit == '0) w_next = DIV_DONE;
            DIV_DONE: begin
                done   = 1'b1;
                w_next = DIV_IDLE;
            end
            default:  w_next = DIV_IDLE;
        endcase
    end

    // Datapath: load operands on start, then one restoring step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_q   <= '0;
        end else if (r_state == DIV_IDLE && start) begin
            r_bit <= BW'(SUM_W - 1);
            r_rem <= '0;
            r_dvs <= divisor;
            r_q   <= dividend;
        end else if (r_state == DIV_RUN) begin
            r_rem <= w_ge ? w_diff[CNT_W-1:0] : w_sh[CNT_W-1:0];
            r_q   <= {r_q[SUM_W-2:0], w_ge};
            r_bit <= r_bit - BW'(1);
        end
    end

    assign quotient = r_q;

endmodule

// File: rtl/skin_centroid.sv
// skin_centroid: per-frame centroid of mask-set pixels from a VGA-style stream.
// Optional bounding-box outputs are enabled with `define SKIN_CENTROID_BBOX_EN.
module skin_centroid
    import skin_pkg::*;
#(
    parameter int         X_W      = DEF_X_W,
    parameter int         Y_W      = DEF_Y_W,
    parameter int         CNT_W    = DEF_CNT_W,
    parameter int         SUM_W    = DEF_SUM_W,
    parameter logic [7:0] MASK_THR = DEF_MASK_THR
)(
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             vga_de,
    input  logic             vga_hs,
    input  logic             vga_vs,
    input  logic [7:0]       mask,
    output logic [X_W-1:0]   cx,
    output logic [Y_W-1:0]   cy,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             empty,
    output logic             res_valid,
    output logic             ovf
`ifdef SKIN_CENTROID_BBOX_EN
    ,
    output logic [X_W-1:0]   bb_xmin,
    output logic [X_W-1:0]   bb_xmax,
    output logic [Y_W-1:0]   bb_ymin,
    output logic [Y_W-1:0]   bb_ymax
`endif
);

    logic             r_de_d, r_vs_d, r_synced, r_go, r_zdone;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [CNT_W-1:0] r_cnt, r_lcnt;
    logic [SUM_W-1:0] r_sx, r_sy, r_lsx, r_lsy;
    logic [SUM_W-1:0] w_qx, w_qy;
    logic             w_busy_x, w_busy_y, w_done_x, w_done_y;
    logic             w_vs_fall, w_de_fall, w_qual, w_div_busy, w_launch, w_start, w_done;
    logic [CNT_W:0]   w_cnt_add;
    logic [SUM_W:0]   w_sx_add, w_sy_add;
    logic             w_unused;

    assign w_vs_fall  = r_vs_d & ~vga_vs;
    assign w_de_fall  = r_de_d & ~vga_de;
    // A qualifying pixel coincident with the frame boundary is ignored
    assign w_qual     = vga_de & (mask >= MASK_THR) & ~w_vs_fall;
    // Busy covers the launch/zero-result pipeline as well as both dividers
    assign w_div_busy = r_go | r_zdone | w_busy_x | w_busy_y;
    assign w_launch   = w_vs_fall & r_synced & ~w_div_busy;
    assign w_start    = r_go & (r_lcnt != '0);
    assign w_done     = w_done_x & w_done_y;

    assign w_cnt_add = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_sx_add  = {1'b0, r_sx} + {{(SUM_W+1-X_W){1'b0}}, r_x};
    assign w_sy_add  = {1'b0, r_sy} + {{(SUM_W+1-Y_W){1'b0}}, r_y};
    assign w_unused  = ^{vga_hs, w_qx[SUM_W-1:X_W], w_qy[SUM_W-1:Y_W]};

    // Delayed de/vs for edge detection
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_d <= 1'b0;
            r_vs_d <= 1'b1;
        end else begin
            r_de_d <= vga_de;
            r_vs_d <= vga_vs;
        end
    end

    // Pixel coordinates recovered from de/vs, saturating
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_vs_fall) begin
            r_x <= '0;
            r_y <= '0;
        end else if (vga_de) begin
            if (!(&r_x)) r_x <= r_x + X_W'(1);
        end else if (w_de_fall) begin
            r_x <= '0;
            if (!(&r_y)) r_y <= r_y + Y_W'(1);
        end
    end

    // Saturating per-frame accumulators using pre-increment coordinates
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
        end else if (w_vs_fall) begin
            r_cnt <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
        end else if (w_qual) begin
            r_cnt <= w_cnt_add[CNT_W] ? '1 : w_cnt_add[CNT_W-1:0];
            r_sx  <= w_sx_add[SUM_W]  ? '1 : w_sx_add[SUM_W-1:0];
            r_sy  <= w_sy_add[SUM_W]  ? '1 : w_sy_add[SUM_W-1:0];
        end
    end

    // Frame boundary: sync on first fall, then launch or drop with sticky overflow
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_synced <= 1'b0;
            r_go     <= 1'b0;
            r_zdone  <= 1'b0;
            r_lcnt   <= '0;
            r_lsx    <= '0;
            r_lsy    <= '0;
            ovf      <= 1'b0;
        end else begin
            r_go    <= w_launch;
            r_zdone <= r_go & (r_lcnt == '0);
            if (w_vs_fall && !r_synced) r_synced <= 1'b1;
            if (w_launch) begin
                r_lcnt <= r_cnt;
                r_lsx  <= r_sx;
                r_lsy  <= r_sy;
            end
            if (w_vs_fall && r_synced && w_div_busy) ovf <= 1'b1;
        end
    end

    centroid_div #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_x (
        .clk(vga_clk), .rst_n(rst_n), .start(w_start), .dividend(r_lsx), .divisor(r_lcnt),
        .busy(w_busy_x), .done(w_done_x), .quotient(w_qx)
    );

    centroid_div #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_y (
        .clk(vga_clk), .rst_n(rst_n), .start(w_start), .dividend(r_lsy), .divisor(r_lcnt),
        .busy(w_busy_y), .done(w_done_y), .quotient(w_qy)
    );

    // Result registers, updated together with the res_valid pulse
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            cx        <= '0;
            cy        <= '0;
            pix_cnt   <= '0;
            empty     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= w_done | r_zdone;
            if (r_zdone) begin
                cx      <= '0;
                cy      <= '0;
                pix_cnt <= '0;
                empty   <= 1'b1;
            end else if (w_done) begin
                cx      <= w_qx[X_W-1:0];
                cy      <= w_qy[Y_W-1:0];
                pix_cnt <= r_lcnt;
                empty   <= 1'b0;
            end
        end
    end

`ifdef SKIN_CENTROID_BBOX_EN
    logic [X_W-1:0] r_bxmin, r_bxmax, r_lbxmin, r_lbxmax;
    logic [Y_W-1:0] r_bymin, r_bymax, r_lbymin, r_lbymax;

    // Bounding-box tracking per frame, latched at launch and published with the result
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bxmin <= '1; r_bxmax <= '0; r_bymin <= '1; r_bymax <= '0;
            r_lbxmin <= '0; r_lbxmax <= '0; r_lbymin <= '0; r_lbymax <= '0;
            bb_xmin <= '0; bb_xmax <= '0; bb_ymin <= '0; bb_ymax <= '0;
        end else begin
            if (w_vs_fall) begin
                r_bxmin <= '1; r_bxmax <= '0; r_bymin <= '1; r_bymax <= '0;
            end else if (w_qual) begin
                if (r_x < r_bxmin) r_bxmin <= r_x;
                if (r_x > r_bxmax) r_bxmax <= r_x;
                if (r_y < r_bymin) r_bymin <= r_y;
                if (r_y > r_bymax) r_bymax <= r_y;
            end
            if (w_launch) begin
                r_lbxmin <= r_bxmin; r_lbxmax <= r_bxmax;
                r_lbymin <= r_bymin; r_lbymax <= r_bymax;
            end
            if (r_zdone) begin
                bb_xmin <= '0; bb_xmax <= '0; bb_ymin <= '0; bb_ymax <= '0;
            end else if (w_done) begin
                bb_xmin <= r_lbxmin; bb_xmax <= r_lbxmax;
                bb_ymin <= r_lbymin; bb_ymax <= r_lbymax;
            end
        end
    end
`endif

endmodule

// File: tb/tb_skin_centroid.sv
// tb_skin_centroid: directed frames with a result scoreboard for skin_centroid.
module tb_skin_centroid;

    localparam int XW = 11, YW = 11, CW = 22, SW = 33;
    localparam int HBP = 3, HFP = 3, VBP = 128, VFP = 128, VSL = 2, ACT = 16;

    typedef struct {
        logic [XW-1:0] cx;
        logic [YW-1:0] cy;
        logic [CW-1:0] cnt;
        logic          empty;
        int            cyc;
    } exp_t;

    logic          vga_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          vga_de  = 1'b0;
    logic          vga_hs  = 1'b1;
    logic          vga_vs  = 1'b1;
    logic [7:0]    mask    = 8'd0;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [CW-1:0] pix_cnt;
    logic          empty, res_valid, ovf;
`ifdef SKIN_CENTROID_BBOX_EN
    logic [XW-1:0] bb_xmin, bb_xmax;
    logic [YW-1:0] bb_ymin, bb_ymax;
`endif

    skin_centroid dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .vga_de(vga_de), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .mask(mask), .cx(cx), .cy(cy), .pix_cnt(pix_cnt),
        .empty(empty), .res_valid(res_valid), .ovf(ovf)
`ifdef SKIN_CENTROID_BBOX_EN
        , .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    exp_t    sb[$];
    int      n_chk = 0, n_pass = 0, n_fail = 0;
    longint  m_cnt = 0, m_sx = 0, m_sy = 0;
    bit      m_synced = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int pat, input int c, input int r);
        case (pat)
            0:       return (c == 5 && r == 3) ? 8'd255 : 8'd0;
            1:       return 8'd255;
            3:       return (c == 2 && r == 2) ? 8'd127 : ((c == 9 && r == 4) ? 8'd128 : 8'd0);
            default: return 8'd0;
        endcase
    endfunction

    // Frame-boundary bookkeeping, called right after vga_vs is driven low
    task automatic book(input bit drop);
        exp_t e;
        if (!m_synced) m_synced = 1;
        else if (!drop) begin
            e.cnt   = CW'(m_cnt);
            e.empty = (m_cnt == 0);
            e.cx    = (m_cnt == 0) ? '0 : XW'(m_sx / m_cnt);
            e.cy    = (m_cnt == 0) ? '0 : YW'(m_sy / m_cnt);
            e.cyc   = cyc + 1 + ((m_cnt == 0) ? 2 : SW + 2);
            sb.push_back(e);
        end
        m_cnt = 0; m_sx = 0; m_sy = 0;
    endtask

    task automatic line(input int row, input int pat);
        vga_hs = 1'b0; vga_de = 1'b0; mask = 8'd0; tick();
        vga_hs = 1'b1; repeat (HBP) tick();
        for (int c = 0; c < ACT; c++) begin
            if (row >= 0) begin
                vga_de = 1'b1;
                mask   = pix(pat, c, row);
                if (mask >= 8'd128) begin
                    m_cnt++; m_sx += c; m_sy += row;
                end
            end
            tick();
        end
        vga_de = 1'b0; mask = 8'd0; repeat (HFP) tick();
    endtask

    task automatic frame_rest(input int pat);
        for (int l = 0; l < VBP; l++) line(-1, pat);
        for (int r = 0; r < ACT; r++) line(r, pat);
        for (int l = 0; l < VFP; l++) line(-1, pat);
    endtask

    task automatic frame(input int pat);
        vga_vs = 1'b0;
        book(0);
        for (int l = 0; l < VSL; l++) line(-1, pat);
        vga_vs = 1'b1;
        frame_rest(pat);
    endtask

    // Scoreboard consumer: every res_valid must match the oldest expectation
    always @(negedge vga_clk) begin
        if (rst_n && res_valid) begin
            if (sb.size() == 0) chk("unexpected_res_valid", 64'(res_valid), 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("cx", 64'(cx), 64'(e.cx));
                chk("cy", 64'(cy), 64'(e.cy));
                chk("pix_cnt", 64'(pix_cnt), 64'(e.cnt));
                chk("empty", 64'(empty), 64'(e.empty));
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_cx", 64'(cx), 0);
        chk("rst_cy", 64'(cy), 0);
        chk("rst_pix_cnt", 64'(pix_cnt), 0);
        chk("rst_empty", 64'(empty), 0);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_ovf", 64'(ovf), 0);
        rst_n = 1'b1;
        tick();

        // Single pixel, full, empty, threshold frames
        frame(0);
        frame(1);
        frame(2);
        frame(3);
        frame(1);

        // Two boundaries 10 cycles apart while the divider is busy
        chk("ovf_before", 64'(ovf), 0);
        vga_vs = 1'b0; book(0); repeat (2) tick();
        vga_vs = 1'b1; repeat (8) tick();
        vga_vs = 1'b0; book(1); repeat (2) tick();
        vga_vs = 1'b1; repeat (5) tick();
        chk("ovf_set", 64'(ovf), 1);
        repeat (50) tick();
        frame(3);
        chk("ovf_sticky", 64'(ovf), 1);
        frame(1);

        // Asynchronous reset mid-frame while a division is running
        vga_vs = 1'b0; book(0); repeat (2) tick();
        vga_vs = 1'b1; repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cx", 64'(cx), 0);
        chk("arst_cy", 64'(cy), 0);
        chk("arst_pix_cnt", 64'(pix_cnt), 0);
        chk("arst_empty", 64'(empty), 0);
        chk("arst_ovf", 64'(ovf), 0);
        sb.delete();
        m_synced = 0; m_cnt = 0; m_sx = 0; m_sy = 0;
        repeat (4) tick();
        rst_n = 1'b1;
        tick();
        frame_rest(1);
        frame(0);
        frame(3);
        vga_vs = 1'b0; book(0);
        repeat (60) tick();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/skin_centroid.md
Name: skin_centroid

Overview:
- Downstream consumer of the VGA-style pixel stream: vga_de/vga_hs/vga_vs plus an 8-bit mask channel from the skin classifier.
- Recovers pixel x/y from the sync/enable signals and accumulates per-frame count, sum-x and sum-y of mask-set pixels.
- At each frame boundary, divides the sums by the count to produce the skin-region centroid for the tracking logic.

Parameters:
- X_W, 11, x coordinate width
- Y_W, 11, y coordinate width
- CNT_W, 22, pixel-count width (must be >= X_W+Y_W)
- SUM_W, 33, accumulator/dividend width (CNT_W+X_W; sum-y shares this width)
- MASK_THR, 8'd128, mask pixel counts as skin when mask >= MASK_THR

Ports:
- vga_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vga_de  in  1  active-pixel enable, aligned with mask
- vga_hs  in  1  hsync, active-low (unused except optional line reset)
- vga_vs  in  1  vsync, active-low; falling edge marks frame end
- mask  in  8  mask channel (tlo_r), sampled when vga_de=1
- cx  out  X_W  centroid x
- cy  out  Y_W  centroid y
- pix_cnt  out  CNT_W  mask pixel count of last frame
- empty  out  1  last frame had zero mask pixels
- res_valid  out  1  one-cycle pulse when cx/cy/pix_cnt/empty update
- ovf  out  1  sticky: frame result dropped because the divider was busy

Behaviour:
- Reset, asynchronous while rst_n=0:
  - outputs: cx=0, cy=0, pix_cnt=0, empty=0, res_valid=0, ovf=0.
  - internal: x=0, y=0, accumulators=0, synced=0, divider idle.
- Edge detection uses registered de_d and vs_d (reset value 1 for vs_d, 0 for de_d).
  - vs_fall = vs_d & ~vga_vs.
  - de_fall = de_d & ~vga_de.
- Coordinates:
  - x increments each vga_de=1 cycle and saturates at all-ones.
  - x clears on de_fall.
  - y increments on de_fall and saturates; lines without de do not advance y.
  - x and y both clear on vs_fall.
- Accumulate on each cycle with vga_de=1 and mask>=MASK_THR, using the current (pre-increment) x,y:
  - cnt += 1
  - sx += x
  - sy += y
  - All three saturate; no wrap.
- On vs_fall:
  - If synced=0: set synced=1, clear accumulators, no result. The first frame after reset is partial and is discarded.
  - Else if divider idle: latch cnt/sx/sy into the divider, clear accumulators, start division.
  - Else (divider busy): drop the frame totals, clear accumulators, set ovf.
  - A pixel qualifying in the same cycle as vs_fall is ignored (de is low in vsync in legal timing).
- Division: restoring, one quotient bit per cycle, two instances in parallel (sx/cnt, sy/cnt). The quotient is floor; its low X_W/Y_W bits drive cx/cy.
  - cnt=0: skip division; result is cx=cy=0, empty=1, pix_cnt=0.
- Latency: res_valid asserts exactly SUM_W+2 cycles after the edge sampling vga_vs low (cnt>0), or 2 cycles (cnt=0).
  - cx/cy/pix_cnt/empty update in the same cycle as res_valid and hold until the next result.
- Divider FSM (per instance): IDLE -> RUN (SUM_W cycles, bit counter down to 0) -> DONE (1 cycle, raise done) -> IDLE.
- Reset mid-operation aborts the division. synced returns to 0, so a full frame plus one boundary is needed before the next result.

Optional Feature:
- SKIN_CENTROID_BBOX_EN defined:
  - Adds outputs bb_xmin/bb_xmax (X_W) and bb_ymin/bb_ymax (Y_W).
  - Min/max track over qualifying pixels (min init all-ones, max init 0, re-init on vs_fall).
  - Latched into outputs on res_valid; empty frame gives all 0.
  - Reset value 0.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package skin_pkg:
  - default widths X_W/Y_W/CNT_W/SUM_W and MASK_THR.
  - divider state enum {DIV_IDLE, DIV_RUN, DIV_DONE}.
- One sub-module: centroid_div (parameterised restoring divider)
  - inputs: start, dividend[SUM_W], divisor[CNT_W]
  - outputs: busy, done, quotient[SUM_W]
  - instantiated twice.

Test Plan:
- 16x16 active frame (hbp=3,hfp=3,hs=1; vbp=vfp=128,vs=2), two frames, single pixel mask=255 at (5,3), rest 0 -> second vs_fall gives res_valid after 35 cycles with pix_cnt=1, cx=5, cy=3, empty=0; no res_valid on first vs_fall.
- Full 16x16 mask=255 -> pix_cnt=256, cx=7, cy=7 (1920/256 floored).
- All mask=0 -> res_valid 2 cycles after vs_fall, empty=1, pix_cnt=0, cx=cy=0.
- Threshold: pixels (2,2)=127 and (9,4)=128 -> pix_cnt=1, cx=9, cy=4.
- Force vsync fall pulses 10 cycles apart (divider busy) -> ovf=1 and sticky; first result still correct; second frame produces no res_valid.
- rst_n low mid-frame and mid-division -> all outputs 0 asynchronously; after release, first vs_fall gives no result, next frame gives correct centroid.
